// File: rtl/reg_wr_arbiter.sv
// Write-port controller for reg_file: clears x1..x31 after reset, then round-robins NREQ requesters.
// 1-cycle handshake-to-we latency, one accept per cycle; un-granted requesters hold addr/data while valid.
module reg_wr_arbiter #(
  parameter int NREQ           = 3,
  parameter int XLEN           = 32,
  parameter int AW             = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 we,
  output logic [AW-1:0]        wa,
  output logic [XLEN-1:0]      wd,
  output logic [2:0]           grant_id,
  output logic                 init_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] LAST_REG = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic            we_nxt, init_done_nxt;
  logic [AW-1:0]   wa_nxt;
  logic [XLEN-1:0] wd_nxt;
  logic [2:0]      grant_id_nxt;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  logic [PW:0]     sum;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  // Rotating priority search: first valid requester at or above rr_ptr, modulo NREQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!found && req_valid[sum[PW-1:0]]) begin
        found              = 1'b1;
        gnt[sum[PW-1:0]]   = 1'b1;
        gnt_idx            = sum[PW-1:0];
      end
    end
  end

  assign sel_addr  = req_addr[gnt_idx*AW +: AW];
  assign sel_data  = req_data[gnt_idx*XLEN +: XLEN];
  assign req_ready = (state == RUN) ? gnt : '0;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rr_ptr_nxt    = rr_ptr;
    we_nxt        = 1'b0;
    wa_nxt        = wa;
    wd_nxt        = wd;
    grant_id_nxt  = grant_id;
    init_done_nxt = init_done;
    case (state)
      CLEAR: begin
        we_nxt  = 1'b1;
        wa_nxt  = cnt;
        wd_nxt  = '0;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_REG) begin
          state_nxt     = RUN;
          init_done_nxt = 1'b1;
        end
      end
      RUN: begin
        if (found) begin
          // x0 is hardwired zero: the handshake completes but no write is issued.
          we_nxt       = (sel_addr != '0);
          wa_nxt       = sel_addr;
          wd_nxt       = sel_data;
          grant_id_nxt = 3'(gnt_idx);
          rr_ptr_nxt   = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      init_done <= (CLEAR_ON_RESET == 0);
      cnt       <= AW'(1);
      rr_ptr    <= '0;
      we        <= 1'b0;
      wa        <= '0;
      wd        <= '0;
      grant_id  <= '0;
    end else begin
      state     <= state_nxt;
      init_done <= init_done_nxt;
      cnt       <= cnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
      we        <= we_nxt;
      wa        <= wa_nxt;
      wd        <= wd_nxt;
      grant_id  <= grant_id_nxt;
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: clear sequence, round-robin grants, x0 writes, mid-clear reset,
// and a CLEAR_ON_RESET=0 instance that must grant on the first cycle after reset release.
module tb_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [2:0]  grant_id;
  logic        init_done;

  logic [2:0]  v0;
  logic [14:0] a0;
  logic [95:0] d0;
  logic [2:0]  rdy0;
  logic        we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic [2:0]  gid0;
  logic        done0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_wr_arbiter #(.NREQ(3), .XLEN(32), .AW(5), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .we(we), .wa(wa), .wd(wd), .grant_id(grant_id), .init_done(init_done)
  );

  reg_wr_arbiter #(.NREQ(3), .XLEN(32), .AW(5), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_addr(a0), .req_data(d0),
    .req_ready(rdy0), .we(we0), .wa(wa0), .wd(wd0), .grant_id(gid0), .init_done(done0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Post-edge write-port check, sampled at the following negedge.
  task automatic check_wr(input string tag, input logic e_we, input logic [4:0] e_wa,
                          input logic [31:0] e_wd, input logic [2:0] e_gid);
    check({tag, ".we"}, 64'(we), 64'(e_we));
    check({tag, ".wa"}, 64'(wa), 64'(e_wa));
    check({tag, ".wd"}, 64'(wd), 64'(e_wd));
    check({tag, ".gid"}, 64'(grant_id), 64'(e_gid));
  endtask

  logic [2:0] exp_g [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    v0        = 3'b100;
    a0        = '0;
    d0        = '0;
    a0[10 +: 5]  = 5'd7;
    d0[64 +: 32] = 32'h0000_1234;

    // Reset state of both instances
    @(negedge clk);
    check("rst.we", 64'(we), 64'd0);
    check("rst.wa", 64'(wa), 64'd0);
    check("rst.wd", 64'(wd), 64'd0);
    check("rst.gid", 64'(grant_id), 64'd0);
    check("rst.init_done", 64'(init_done), 64'd0);
    check("rst.ready", 64'(req_ready), 64'd0);
    check("nc.rst.init_done", 64'(done0), 64'd1);
    check("nc.rst.we", 64'(we0), 64'd0);
    rst = 1'b1;

    // Clear sequence: wa=1..31, wd=0, ready low until RUN
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("clr%0d.we", i), 64'(we), 64'd1);
      check($sformatf("clr%0d.wa", i), 64'(wa), 64'(i));
      check($sformatf("clr%0d.wd", i), 64'(wd), 64'd0);
      check($sformatf("clr%0d.init_done", i), 64'(init_done), 64'(i == 31));
      if (i < 31) check($sformatf("clr%0d.ready", i), 64'(req_ready), 64'd0);
      if (i == 1) begin
        check("nc.first.we", 64'(we0), 64'd1);
        check("nc.first.wa", 64'(wa0), 64'd7);
        check("nc.first.wd", 64'(wd0), 64'h1234);
        check("nc.first.gid", 64'(gid0), 64'd2);
        v0 = '0;
      end
    end

    // All three valid for six cycles: 0,1,2,0,1,2 with no bubbles
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr%0d.ready", k), 64'(req_ready), 64'(3'b001 << exp_g[k]));
      @(posedge clk);
      @(negedge clk);
      case (exp_g[k])
        3'd0:    check_wr($sformatf("rr%0d", k), 1'b1, 5'd1, 32'hA0A0_A0A0, 3'd0);
        3'd1:    check_wr($sformatf("rr%0d", k), 1'b1, 5'd2, 32'hA1A1_A1A1, 3'd1);
        default: check_wr($sformatf("rr%0d", k), 1'b1, 5'd3, 32'hA2A2_A2A2, 3'd2);
      endcase
    end

    // Single requester 1, address 5
    req_valid = 3'b010;
    req_addr  = '0;
    req_data  = '0;
    req_addr[5 +: 5]   = 5'd5;
    req_data[32 +: 32] = 32'hDEAD_BEEF;
    #1;
    check("one.ready", 64'(req_ready), 64'(3'b010));
    @(posedge clk);
    @(negedge clk);
    check_wr("one", 1'b1, 5'd5, 32'hDEAD_BEEF, 3'd1);

    // Idle cycle: we drops, wa/wd/grant_id hold
    req_valid = '0;
    #1;
    check("idle.ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_wr("idle", 1'b0, 5'd5, 32'hDEAD_BEEF, 3'd1);

    // x0 write from requester 0 while pointer sits at 2: granted, no write
    req_valid = 3'b001;
    req_addr  = '0;
    req_data  = '0;
    req_data[0 +: 32] = 32'h5555_AAAA;
    #1;
    check("x0.ready", 64'(req_ready), 64'(3'b001));
    @(posedge clk);
    @(negedge clk);
    check("x0.we", 64'(we), 64'd0);
    check("x0.gid", 64'(grant_id), 64'd0);

    // Pointer advanced past 0 despite the dropped write
    req_valid = 3'b111;
    req_addr  = {5'd13, 5'd12, 5'd11};
    req_data  = {32'hC2, 32'hC1, 32'hC0};
    #1;
    check("after_x0.ready", 64'(req_ready), 64'(3'b010));
    @(posedge clk);
    @(negedge clk);
    check_wr("after_x0", 1'b1, 5'd12, 32'hC1, 3'd1);
    req_valid = '0;

    // Reset in RUN, then again mid-clear at wa=10
    rst = 1'b0;
    #1;
    check("runrst.init_done", 64'(init_done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst.wa", 64'(wa), 64'd10);
    check("pre_rst.we", 64'(we), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst.we", 64'(we), 64'd0);
    check("midrst.wa", 64'(wa), 64'd0);
    check("midrst.init_done", 64'(init_done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart.we", 64'(we), 64'd1);
    check("restart.wa", 64'(wa), 64'd1);
    check("restart.init_done", 64'(init_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
